// File: rtl/peripheral_irrigation_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_irrigation_ctrl_if
// Description : FemtoRV32 peripheral bus bundle for the irrigation sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_irrigation_ctrl_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;

    modport master (output cs, rd, wr, addr, d_in, input d_out);
    modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface
`default_nettype wire

// File: rtl/peripheral_irrigation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_irrigation_ctrl
// Description : Memory-mapped irrigation sequencer: debounced soil sensors,
//               IDLE/WATER/HOLD/FAULT valve FSM, LED status. Optional IRQ
//               block enabled by defining IRRIG_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_irrigation_ctrl #(
    parameter int TICK_DIV  = 25000,
    parameter int CNT_W     = 16,
    parameter int DEB_TICKS = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    peripheral_irrigation_ctrl_if.slave bus,
    input  logic                       sensor_lo_i,
    input  logic                       sensor_hi_i,
    output logic                       valve_o,
    output logic [3:0]                 leds_o,
    output logic                       irq_o
);

    localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DEB_W = $clog2(DEB_TICKS + 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_TICKS - 1);

    localparam logic [4:0] c_ADDR_CTRL   = 5'h00;
    localparam logic [4:0] c_ADDR_ON     = 5'h04;
    localparam logic [4:0] c_ADDR_OFF    = 5'h08;
    localparam logic [4:0] c_ADDR_STATUS = 5'h0C;
    localparam logic [4:0] c_ADDR_CYCLES = 5'h10;
    localparam logic [4:0] c_ADDR_IRQ    = 5'h14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WATER = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    logic [c_PRE_W-1:0] presc_q;
    logic               tick;
    logic [1:0]         sens_meta_q;
    logic [1:0]         sens_sync_q;
    logic [1:0]         sens_db;
    logic               lo_db;
    logic               hi_db;

    state_t             state_q;
    logic [CNT_W-1:0]   timer_q;
    logic               valve_q;
    logic [1:0]         fault_code_q;
    logic [15:0]        cycles_q;
    logic               enable_q;
    logic [CNT_W-1:0]   on_time_q;
    logic [CNT_W-1:0]   off_time_q;
    logic [31:0]        d_out_q;
    logic [31:0]        rdata;
    logic [31:0]        irq_rdata;

    logic               bus_wr;
    logic               bus_rd;
    logic               fault_clr;
    logic               both_db;
    logic               fault_entry;
    logic               cycle_done;
    logic               unused_bits;

    // ---------------- tick prescaler ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q <= '0;
        end else if (presc_q == c_PRE_LAST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick = (presc_q == c_PRE_LAST);

    // ---------------- sensor sync + debounce ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sens_meta_q <= 2'b00;
            sens_sync_q <= 2'b00;
        end else begin
            sens_meta_q <= {sensor_hi_i, sensor_lo_i};
            sens_sync_q <= sens_meta_q;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic [c_DEB_W-1:0] cnt_q;
        logic               db_q;

        // Any tick where the input agrees with the held value restarts the run.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else if (sens_sync_q[gi] == db_q) begin
                cnt_q <= '0;
            end else if (tick) begin
                if (cnt_q == c_DEB_LAST) begin
                    cnt_q <= '0;
                    db_q  <= sens_sync_q[gi];
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign sens_db[gi] = db_q;
    end

    assign lo_db = sens_db[0];
    assign hi_db = sens_db[1];

    // ---------------- bus decode and config registers ----------------
    assign bus_wr    = bus.cs & bus.wr;
    assign bus_rd    = bus.cs & bus.rd;
    assign fault_clr = bus_wr & (bus.addr == c_ADDR_CTRL) & bus.d_in[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_q   <= 1'b0;
            on_time_q  <= '0;
            off_time_q <= '0;
        end else if (bus_wr) begin
            if (bus.addr == c_ADDR_CTRL) enable_q   <= bus.d_in[0];
            if (bus.addr == c_ADDR_ON)   on_time_q  <= bus.d_in[CNT_W-1:0];
            if (bus.addr == c_ADDR_OFF)  off_time_q <= bus.d_in[CNT_W-1:0];
        end
    end

    // ---------------- sequencer FSM ----------------
    assign both_db     = lo_db & hi_db;
    assign fault_entry = (state_q == ST_WATER) ? hi_db : ((state_q != ST_FAULT) & both_db);
    assign cycle_done  = (state_q == ST_WATER) & ~hi_db & enable_q &
                         ((timer_q == '0) | ~lo_db);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            valve_q      <= 1'b0;
            fault_code_q <= 2'd0;
            cycles_q     <= 16'd0;
        end else begin
            if (bus_wr && (bus.addr == c_ADDR_CYCLES)) begin
                cycles_q <= 16'd0;
            end else if (cycle_done) begin
                cycles_q <= cycles_q + 16'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (fault_entry) begin
                        state_q      <= ST_FAULT;
                        fault_code_q <= 2'd2;
                    end else if (enable_q && lo_db && !hi_db && (on_time_q != '0)) begin
                        state_q <= ST_WATER;
                        timer_q <= on_time_q;
                        valve_q <= 1'b1;
                    end
                end
                ST_WATER: begin
                    if (fault_entry) begin
                        state_q      <= ST_FAULT;
                        fault_code_q <= 2'd1;
                        valve_q      <= 1'b0;
                    end else if (!enable_q) begin
                        state_q <= ST_IDLE;
                        valve_q <= 1'b0;
                    end else if (cycle_done) begin
                        state_q <= ST_HOLD;
                        timer_q <= off_time_q;
                        valve_q <= 1'b0;
                    end else if (tick) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (fault_entry) begin
                        state_q      <= ST_FAULT;
                        fault_code_q <= 2'd2;
                    end else if (!enable_q || (timer_q == '0)) begin
                        state_q <= ST_IDLE;
                    end else if (tick) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    valve_q <= 1'b0;
                    // A clear is refused while the sensors still contradict each other.
                    if (fault_clr && !both_db) begin
                        state_q      <= ST_IDLE;
                        fault_code_q <= 2'd0;
                    end
                end
            endcase
        end
    end

    // ---------------- optional interrupt block ----------------
`ifdef IRRIG_IRQ_EN
    logic [1:0] irq_pend_q;
    logic [1:0] irq_pend_d;
    logic [1:0] irq_mask_q;
    logic [1:0] irq_mask_d;
    logic       irq_q;

    // New events win over a simultaneous write-1-to-clear.
    always_comb begin
        irq_pend_d = irq_pend_q;
        irq_mask_d = irq_mask_q;
        if (bus_wr && (bus.addr == c_ADDR_IRQ)) begin
            irq_pend_d = irq_pend_q & ~bus.d_in[1:0];
            irq_mask_d = bus.d_in[9:8];
        end
        if (fault_entry) irq_pend_d[0] = 1'b1;
        if (cycle_done)  irq_pend_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_pend_q <= 2'b00;
            irq_mask_q <= 2'b00;
            irq_q      <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= |(irq_pend_d & irq_mask_d);
        end
    end

    assign irq_rdata = {22'd0, irq_mask_q, 6'd0, irq_pend_q};
    assign irq_o     = irq_q;
`else
    assign irq_rdata = 32'd0;
    assign irq_o     = 1'b0;
`endif

    // ---------------- read path ----------------
    always_comb begin
        rdata = 32'd0;
        case (bus.addr)
            c_ADDR_CTRL:   rdata = {31'd0, enable_q};
            c_ADDR_ON:     rdata = 32'(on_time_q);
            c_ADDR_OFF:    rdata = 32'(off_time_q);
            c_ADDR_STATUS: rdata = {26'd0, fault_code_q, hi_db, lo_db, state_q};
            c_ADDR_CYCLES: rdata = {16'd0, cycles_q};
            c_ADDR_IRQ:    rdata = irq_rdata;
            default:       rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_out_q <= 32'd0;
        end else if (bus_rd) begin
            d_out_q <= rdata;
        end else begin
            d_out_q <= 32'd0;
        end
    end

    assign bus.d_out = d_out_q;
    assign valve_o   = valve_q;
    assign leds_o    = {(state_q == ST_FAULT), hi_db, lo_db,
                        ~(hi_db | lo_db) & (state_q != ST_FAULT)};
    assign unused_bits = ^bus.d_in;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_irrigation_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_irrigation_ctrl
// Description : Directed self-checking bench for peripheral_irrigation_ctrl
//               (TICK_DIV=4, DEB_TICKS=2); IRQ checks follow IRRIG_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_irrigation_ctrl;

    logic        clk;
    logic        resetn;
    logic        sensor_lo;
    logic        sensor_hi;
    logic        valve;
    logic [3:0]  leds;
    logic        irq;
    logic [31:0] rd_data;
    int          n_cmp;
    int          n_err;

    peripheral_irrigation_ctrl_if bus_if();

    peripheral_irrigation_ctrl #(
        .TICK_DIV  (4),
        .CNT_W     (16),
        .DEB_TICKS (2)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_if),
        .sensor_lo_i (sensor_lo),
        .sensor_hi_i (sensor_hi),
        .valve_o     (valve),
        .leds_o      (leds),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.cs = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.d_in = d;
        @(negedge clk);
        bus_if.cs = 1'b0; bus_if.wr = 1'b0; bus_if.d_in = 32'd0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.cs = 1'b1; bus_if.rd = 1'b1; bus_if.addr = a;
        @(negedge clk);
        bus_if.cs = 1'b0; bus_if.rd = 1'b0;
        d = bus_if.d_out;
    endtask

    task automatic wait_valve(input logic v, input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (valve === v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] addrs [7];
        addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h1C};
        resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sensor_lo = i[0];
            sensor_hi = ~i[0];
            @(posedge clk); #1;
        end
        n_cmp++; if (valve !== 1'b0) begin n_err++; $display("FAIL reset_valve got %b want 0", valve); end
        n_cmp++; if (leds !== 4'b0001) begin n_err++; $display("FAIL reset_leds got %b want 0001", leds); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_cmp++; if (bus_if.d_out !== 32'd0) begin n_err++; $display("FAIL reset_dout got %h want 0", bus_if.d_out); end
        sensor_lo = 1'b0;
        sensor_hi = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        foreach (addrs[k]) begin
            bus_read(addrs[k], rd_data);
            n_cmp++;
            if (rd_data !== 32'd0) begin
                n_err++; $display("FAIL reset_read_%h got %h want 0", addrs[k], rd_data);
            end
        end
    endtask

    task automatic test_normal();
        int cyc;
        bit ok;
        bus_write(5'h04, 32'd10);
        bus_write(5'h08, 32'd5);
        bus_read(5'h04, rd_data);
        n_cmp++; if (rd_data !== 32'd10) begin n_err++; $display("FAIL on_time_rd got %h want 0000000a", rd_data); end
        bus_read(5'h08, rd_data);
        n_cmp++; if (rd_data !== 32'd5) begin n_err++; $display("FAIL off_time_rd got %h want 00000005", rd_data); end
        bus_write(5'h00, 32'd1);
        sensor_lo = 1'b1;
        wait_valve(1'b1, 40, cyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL normal_open got valve=%b want 1 within 40", valve); end
        n_cmp++; if (leds !== 4'b0010) begin n_err++; $display("FAIL normal_leds got %b want 0010", leds); end
        wait_valve(1'b0, 60, cyc, ok);
        n_cmp++;
        if (!ok || cyc < 36 || cyc > 44) begin
            n_err++; $display("FAIL water_len got %0d ok=%0b want 36..44", cyc, ok);
        end
        wait_valve(1'b1, 60, cyc, ok);
        n_cmp++;
        if (!ok || cyc < 16 || cyc > 26) begin
            n_err++; $display("FAIL hold_len got %0d ok=%0b want 16..26", cyc, ok);
        end
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h05) begin n_err++; $display("FAIL status_water got %h want 00000005", rd_data); end
        wait_valve(1'b0, 60, cyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL normal_close2 got valve=%b want 0", valve); end
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h06) begin n_err++; $display("FAIL status_hold got %h want 00000006", rd_data); end
        bus_read(5'h10, rd_data);
        n_cmp++; if (rd_data !== 32'd2) begin n_err++; $display("FAIL cycles_two got %h want 00000002", rd_data); end
        bus_write(5'h00, 32'd0);
        sensor_lo = 1'b0;
        repeat (30) @(posedge clk);
    endtask

    task automatic test_overflow();
        int cyc;
        bit ok;
        bus_write(5'h04, 32'd100);
        bus_write(5'h00, 32'd1);
        sensor_lo = 1'b1;
        wait_valve(1'b1, 40, cyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_open got valve=%b want 1", valve); end
        sensor_hi = 1'b1;
        wait_valve(1'b0, 40, cyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_close got valve=%b want 0", valve); end
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h1F) begin n_err++; $display("FAIL ovf_status got %h want 0000001f", rd_data); end
        n_cmp++; if (leds !== 4'b1110) begin n_err++; $display("FAIL ovf_leds got %b want 1110", leds); end
        bus_write(5'h00, 32'd1);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h1F) begin n_err++; $display("FAIL ovf_enable_ignored got %h want 0000001f", rd_data); end
        sensor_lo = 1'b0;
        repeat (30) @(posedge clk);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h1B) begin n_err++; $display("FAIL ovf_lo_release got %h want 0000001b", rd_data); end
        bus_write(5'h00, 32'd2);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h08) begin n_err++; $display("FAIL ovf_cleared got %h want 00000008", rd_data); end
        n_cmp++; if (leds !== 4'b0100) begin n_err++; $display("FAIL ovf_leds_after got %b want 0100", leds); end
        sensor_hi = 1'b0;
        repeat (30) @(posedge clk);
    endtask

    task automatic test_conflict();
        sensor_lo = 1'b1;
        sensor_hi = 1'b1;
        repeat (30) @(posedge clk);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h2F) begin n_err++; $display("FAIL conflict_status got %h want 0000002f", rd_data); end
        bus_write(5'h00, 32'd2);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h2F) begin n_err++; $display("FAIL conflict_clr_refused got %h want 0000002f", rd_data); end
        sensor_lo = 1'b0;
        repeat (30) @(posedge clk);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h2B) begin n_err++; $display("FAIL conflict_lo_release got %h want 0000002b", rd_data); end
        bus_write(5'h00, 32'd2);
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h08) begin n_err++; $display("FAIL conflict_cleared got %h want 00000008", rd_data); end
        sensor_hi = 1'b0;
        repeat (30) @(posedge clk);
        n_cmp++; if (leds !== 4'b0001) begin n_err++; $display("FAIL conflict_leds_idle got %b want 0001", leds); end
    endtask

    task automatic test_enable_drop();
        int cyc;
        int highs;
        bit ok;
        bus_write(5'h10, 32'hFFFF_FFFF);
        bus_read(5'h10, rd_data);
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL cycles_clear got %h want 0", rd_data); end
        bus_write(5'h04, 32'd100);
        bus_write(5'h00, 32'd1);
        sensor_lo = 1'b1;
        wait_valve(1'b1, 40, cyc, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL drop_open got valve=%b want 1", valve); end
        bus_write(5'h00, 32'd0);
        @(posedge clk); #1;
        n_cmp++; if (valve !== 1'b0) begin n_err++; $display("FAIL drop_close got valve=%b want 0", valve); end
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h04) begin n_err++; $display("FAIL drop_status got %h want 00000004", rd_data); end
        bus_read(5'h10, rd_data);
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL drop_no_cycle got %h want 0", rd_data); end
        bus_write(5'h04, 32'd0);
        bus_write(5'h00, 32'd1);
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (valve !== 1'b0) highs++;
        end
        n_cmp++; if (highs != 0) begin n_err++; $display("FAIL on_zero_valve got %0d high cycles want 0", highs); end
        bus_read(5'h0C, rd_data);
        n_cmp++; if (rd_data !== 32'h04) begin n_err++; $display("FAIL on_zero_status got %h want 00000004", rd_data); end
    endtask

    task automatic test_irq();
`ifdef IRRIG_IRQ_EN
        int cyc;
        bit ok;
        bus_write(5'h14, 32'h200);
        bus_write(5'h08, 32'd50);
        bus_write(5'h04, 32'd2);
        wait_valve(1'b1, 10, cyc, ok);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle got %b want 0", irq); end
        wait_valve(1'b0, 20, cyc, ok);
        n_cmp++; if (!ok || irq !== 1'b1) begin n_err++; $display("FAIL irq_cycle got %b ok=%0b want 1", irq, ok); end
        bus_read(5'h14, rd_data);
        n_cmp++; if (rd_data !== 32'h203) begin n_err++; $display("FAIL irq_reg got %h want 00000203", rd_data); end
        bus_write(5'h14, 32'h2);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared got %b want 0", irq); end
        bus_read(5'h14, rd_data);
        n_cmp++; if (rd_data !== 32'h1) begin n_err++; $display("FAIL irq_reg_after got %h want 00000001", rd_data); end
`else
        bus_write(5'h14, 32'h303);
        bus_read(5'h14, rd_data);
        n_cmp++; if (rd_data !== 32'd0) begin n_err++; $display("FAIL irq_reg_absent got %h want 0", rd_data); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_tied got %b want 0", irq); end
`endif
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        resetn      = 1'b0;
        sensor_lo   = 1'b0;
        sensor_hi   = 1'b0;
        bus_if.cs   = 1'b0;
        bus_if.rd   = 1'b0;
        bus_if.wr   = 1'b0;
        bus_if.addr = 5'd0;
        bus_if.d_in = 32'd0;
        test_reset();
        test_normal();
        test_overflow();
        test_conflict();
        test_enable_drop();
        test_irq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
